cnn_stream_driver: RTL

CNN_STREAM_DRIVER -- requirements
Module: cnn_stream_driver

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/cnn_sync_fifo.sv | 64 ++++++
 rtl/cnn_stream_driver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg -- definitions shared by the CNN stream driver and its input FIFO.
//   cnn_state_e : driver FSM states (IDLE, FEED, WAIT_DONE, RESULT)
//   CNN_*       : default parameter values
//   cnn_width() : index width for n entries, never less than 1 bit
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FEED      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESULT    = 2'd3
  } cnn_state_e;

  localparam int CNN_DATA_W      = 32;
  localparam int CNN_PIXELS      = 784;
  localparam int CNN_NUM_CLASSES = 10;
  localparam int CNN_FIFO_DEPTH  = 16;

  function automatic int cnn_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_sync_fifo.sv
// cnn_sync_fifo -- single-clock show-ahead FIFO feeding the CNN driver.
// Ports:
//   clk, rstn        clock, async active-low reset (empties the FIFO)
//   i_push/i_wr_data write request and data (ignored when full)
//   i_pop            read request (ignored when empty)
//   o_rd_data        head word, valid whenever o_empty is low
//   o_full/o_empty   occupancy flags
// FIFO_DEPTH must be a power of two so the pointers wrap by overflow.
module cnn_sync_fifo
  import cnn_pkg::*;
#(
  parameter int DATA_W     = CNN_DATA_W,
  parameter int FIFO_DEPTH = CNN_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = cnn_width(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cnn_stream_driver.sv
// cnn_stream_driver -- buffers host pixels and streams one image at a time
// into a CNN core, then holds the classification result for the host.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   s_data/s_valid/s_ready          host pixel stream into the FIFO
//   cnn_start                       high while an image is being fed
//   cnn_din/cnn_din_ready           pixel to the CNN, consumed on ready edges
//   cnn_conv1_done/cnn_done         CNN progress strobes
//   cnn_classes                     CNN class bits, captured on cnn_done
//   res_valid/res_ready             result handshake to the host
//   res_classes/res_idx/res_multi   captured classes and argmax summary
//   underrun/proto_err              sticky error flags (cleared by reset only)
//   img_count                       completed images, wraps at 2^16
// Build option: define CNN_ARGMAX_EN to fill res_idx/res_multi from the
// captured classes; otherwise both are tied to 0.
module cnn_stream_driver
  import cnn_pkg::*;
#(
  parameter int DATA_W      = CNN_DATA_W,
  parameter int PIXELS      = CNN_PIXELS,
  parameter int NUM_CLASSES = CNN_NUM_CLASSES,
  parameter int FIFO_DEPTH  = CNN_FIFO_DEPTH,
  localparam int IDX_W      = cnn_width(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   cnn_start,
  output logic [DATA_W-1:0]      cnn_din,
  input  logic                   cnn_din_ready,
  input  logic                   cnn_conv1_done,
  input  logic                   cnn_done,
  input  logic [NUM_CLASSES-1:0] cnn_classes,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NUM_CLASSES-1:0] res_classes,
  output logic [IDX_W-1:0]       res_idx,
  output logic                   res_multi,
  output logic                   underrun,
  output logic                   proto_err,
  output logic [15:0]            img_count
);

  localparam int CNT_W = cnn_width(PIXELS + 1);

  cnn_state_e             r_state;
  logic [CNT_W-1:0]       r_pix_cnt;
  logic [DATA_W-1:0]      r_din;
  logic                   r_underrun;
  logic                   r_proto_err;
  logic [15:0]            r_img_count;
  logic                   r_res_valid;
  logic [NUM_CLASSES-1:0] r_res_classes;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [DATA_W-1:0]      w_fifo_dout;
  logic                   w_pop;
  logic                   w_capture;
  logic [CNT_W-1:0]       w_cnt_nxt;

  // A pixel is consumed only in FEED; cnn_done and cnn_conv1_done end the
  // feed phase on that same edge, so they suppress the pop.
  assign w_pop     = (r_state == ST_FEED) && cnn_din_ready && !cnn_done &&
                     !cnn_conv1_done && !w_fifo_empty;
  assign w_capture = cnn_done && ((r_state == ST_FEED) || (r_state == ST_WAIT_DONE));
  assign w_cnt_nxt = r_pix_cnt + CNT_W'(1);

  cnn_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_push    (s_valid),
    .i_wr_data (s_data),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_dout),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign s_ready     = !w_fifo_full;
  assign cnn_start   = (r_state == ST_FEED);
  assign cnn_din     = r_din;
  assign underrun    = r_underrun;
  assign proto_err   = r_proto_err;
  assign img_count   = r_img_count;
  assign res_valid   = r_res_valid;
  assign res_classes = r_res_classes;

  // Image sequencing FSM with its registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_pix_cnt     <= {CNT_W{1'b0}};
      r_din         <= {DATA_W{1'b0}};
      r_underrun    <= 1'b0;
      r_proto_err   <= 1'b0;
      r_img_count   <= 16'd0;
      r_res_valid   <= 1'b0;
      r_res_classes <= {NUM_CLASSES{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_state   <= ST_FEED;
            r_pix_cnt <= {CNT_W{1'b0}};
          end
        end
        ST_FEED: begin
          if (cnn_done) begin
            // Early completion: leftover pixels stay queued for the next image.
            r_res_classes <= cnn_classes;
            r_proto_err   <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= ST_RESULT;
          end else if (cnn_conv1_done) begin
            r_state <= ST_WAIT_DONE;
          end else if (cnn_din_ready) begin
            // An empty FIFO still advances the image, padding with zero.
            r_din     <= w_fifo_empty ? {DATA_W{1'b0}} : w_fifo_dout;
            r_pix_cnt <= w_cnt_nxt;
            if (w_fifo_empty) r_underrun <= 1'b1;
            if (w_cnt_nxt == CNT_W'(PIXELS)) r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (cnn_done) begin
            r_res_classes <= cnn_classes;
            r_res_valid   <= 1'b1;
            r_state       <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_img_count <= r_img_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CNN_ARGMAX_EN
  logic [IDX_W-1:0] r_res_idx;
  logic             r_res_multi;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CLASSES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    // Scan downward so the last hit is the lowest set bit.
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Argmax summary, captured together with the class vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_idx   <= {IDX_W{1'b0}};
      r_res_multi <= 1'b0;
    end else if (w_capture) begin
      r_res_idx   <= lowest_set(cnn_classes);
      // Clearing the lowest set bit leaves something only if two or more were set.
      r_res_multi <= |(cnn_classes & (cnn_classes - NUM_CLASSES'(1)));
    end
  end

  assign res_idx   = r_res_idx;
  assign res_multi = r_res_multi;
`else
  assign res_idx   = {IDX_W{1'b0}};
  assign res_multi = 1'b0;
`endif

endmodule
